// File: rtl/jtframe_spi_pkg.sv
// Shared definitions for the SPI ROM download path: ARM command codes,
// the command FSM state encoding and the command decode helper.
package jtframe_spi_pkg;

    localparam logic [7:0] UIO_FILE_TX     = 8'h53;
    localparam logic [7:0] UIO_FILE_TX_DAT = 8'h54;
    localparam logic [7:0] UIO_FILE_INDEX  = 8'h55;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        TX_CTL = 3'd1,
        TX_DAT = 3'd2,
        INDEX  = 3'd3,
        SKIP   = 3'd4
    } state_t;

    // Map the first byte of a frame onto the state that handles the rest of it.
    // Unknown commands park the FSM in SKIP until the frame closes.
    function automatic state_t cmd_decode(input logic [7:0] cmd);
        state_t nxt;
        case (cmd)
            UIO_FILE_TX:     nxt = TX_CTL;
            UIO_FILE_TX_DAT: nxt = TX_DAT;
            UIO_FILE_INDEX:  nxt = INDEX;
            default:         nxt = SKIP;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/jtframe_spi_rx.sv
// SPI mode-0 byte receiver oversampled in clk. Synchronises SCK, SS2 and DI,
// detects SCK rising edges inside a frame and assembles bytes MSB first.
// After reset the receiver stays deaf until SS2 has been seen high, so a
// frame interrupted by reset is ignored to its end.
module jtframe_spi_rx #(
    parameter int SYNC = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       spi_sck,
    input  logic       spi_ss2,
    input  logic       spi_di,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       frame_end
);

    logic [SYNC-1:0] sck_sync_r;
    logic [SYNC-1:0] ss2_sync_r;
    logic [SYNC-1:0] di_sync_r;
    logic            sck_d_r;
    logic            ss2_d_r;
    logic            armed_r;
    logic [2:0]      bit_cnt_r;
    logic [6:0]      shift_r;

    logic sck_s;
    logic ss2_s;
    logic di_s;
    logic sck_rise_s;
    logic ss2_rise_s;

    assign sck_s      = sck_sync_r[SYNC-1];
    assign ss2_s      = ss2_sync_r[SYNC-1];
    assign di_s       = di_sync_r[SYNC-1];
    assign sck_rise_s = sck_s & ~sck_d_r & ~ss2_s & armed_r;
    assign ss2_rise_s = ss2_s & ~ss2_d_r;

    // Synchroniser chains for the three asynchronous SPI pins. SS2 resets low
    // so that only a genuine high level on the pin can arm the receiver.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sck_sync_r <= '0;
            ss2_sync_r <= '0;
            di_sync_r  <= '0;
            sck_d_r    <= 1'b0;
            ss2_d_r    <= 1'b0;
        end else begin
            sck_sync_r <= {sck_sync_r[SYNC-2:0], spi_sck};
            ss2_sync_r <= {ss2_sync_r[SYNC-2:0], spi_ss2};
            di_sync_r  <= {di_sync_r[SYNC-2:0], spi_di};
            sck_d_r    <= sck_s;
            ss2_d_r    <= ss2_s;
        end
    end

    // Arm once SS2 is seen deasserted; a frame already open at reset is skipped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            armed_r <= 1'b0;
        end else if (ss2_s) begin
            armed_r <= 1'b1;
        end
    end

    // Shift in DI on each in-frame SCK rise, emit a byte every 8th edge and
    // drop any partial byte when the frame closes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt_r <= 3'd0;
            shift_r   <= 7'd0;
            rx_byte   <= 8'd0;
            rx_valid  <= 1'b0;
            frame_end <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            frame_end <= ss2_rise_s;
            if (sck_rise_s) begin
                shift_r <= {shift_r[5:0], di_s};
                if (bit_cnt_r == 3'd7) begin
                    rx_byte   <= {shift_r, di_s};
                    rx_valid  <= 1'b1;
                    bit_cnt_r <= 3'd0;
                end else begin
                    bit_cnt_r <= bit_cnt_r + 3'd1;
                end
            end else if (ss2_rise_s) begin
                bit_cnt_r <= 3'd0;
            end
        end
    end

endmodule

// File: rtl/jtframe_spi_dwnld.sv
// ROM download slave for the MiST ARM IO controller. Decodes file-transfer
// frames on SPI_SS2 and produces the ioctl byte-write stream.
module jtframe_spi_dwnld
    import jtframe_spi_pkg::*;
#(
    parameter int AW   = 22,
    parameter int SYNC = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          SPI_SCK,
    input  logic          SPI_SS2,
    input  logic          SPI_DI,
    output logic [7:0]    ioctl_index,
    output logic [AW-1:0] ioctl_addr,
    output logic [7:0]    ioctl_data,
    output logic          ioctl_wr,
    output logic          downloading,
    output logic          overflow
);

    localparam logic [AW-1:0] ADDR_MAX = {AW{1'b1}};
    localparam logic [AW-1:0] ADDR_ONE = AW'(1);

    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       frame_end;
    state_t     state_r;
    // Set once the top address has been written; later data bytes overflow.
    logic       full_r;

    jtframe_spi_rx #(
        .SYNC (SYNC)
    ) u_rx (
        .clk       (clk),
        .rst       (rst),
        .spi_sck   (SPI_SCK),
        .spi_ss2   (SPI_SS2),
        .spi_di    (SPI_DI),
        .rx_byte   (rx_byte),
        .rx_valid  (rx_valid),
        .frame_end (frame_end)
    );

    // Command FSM plus address counter. The address advances the clk after each
    // strobe and saturates at the top of the space. A byte completing in the
    // same clk as the frame end is handled first, then the FSM returns to IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            ioctl_index <= 8'd0;
            ioctl_addr  <= '0;
            ioctl_data  <= 8'd0;
            ioctl_wr    <= 1'b0;
            downloading <= 1'b0;
            overflow    <= 1'b0;
            full_r      <= 1'b0;
        end else begin
            ioctl_wr <= 1'b0;
            if (ioctl_wr) begin
                if (ioctl_addr == ADDR_MAX) begin
                    full_r <= 1'b1;
                end else begin
                    ioctl_addr <= ioctl_addr + ADDR_ONE;
                end
            end
            if (rx_valid) begin
                case (state_r)
                    IDLE: begin
                        state_r <= cmd_decode(rx_byte);
                    end
                    TX_CTL: begin
                        if (rx_byte != 8'h00) begin
                            downloading <= 1'b1;
                            ioctl_addr  <= '0;
                            overflow    <= 1'b0;
                            full_r      <= 1'b0;
                        end else begin
                            downloading <= 1'b0;
                        end
                        state_r <= SKIP;
                    end
                    TX_DAT: begin
                        if (downloading) begin
                            if (full_r) begin
                                overflow <= 1'b1;
                            end else begin
                                ioctl_wr   <= 1'b1;
                                ioctl_data <= rx_byte;
                            end
                        end
                    end
                    INDEX: begin
                        ioctl_index <= rx_byte;
                        state_r     <= SKIP;
                    end
                    SKIP: begin
                        state_r <= SKIP;
                    end
                    default: begin
                        state_r <= IDLE;
                    end
                endcase
            end
            if (frame_end) begin
                state_r <= IDLE;
            end
        end
    end

endmodule
